// File: rtl/st_align_buf.sv
// Store alignment buffer: lane-replicates SW/SH/SB data, builds big-endian byte
// enables, queues aligned writes and drains them to data memory via req/ack.
module st_align_buf #(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        st_valid,
   input  logic [1:0]  st_op,
   input  logic [31:0] st_addr,
   input  logic [31:0] st_data,
   output logic        st_ready,
   output logic        st_misalign,
   input  logic        ld_valid,
   input  logic [31:0] ld_addr,
   output logic        ld_hazard,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic        mem_ack,
   output logic        empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;

   logic [29:0]   addr_q [DEPTH];
   logic [31:0]   data_q [DEPTH];
   logic [3:0]    be_q   [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;

   logic        accept_ok;
   logic [31:0] lane_data;
   logic [3:0]  lane_be;
   logic        full;
   logic        push;
   logic        pop;

   always_comb begin
      accept_ok = 1'b0;
      lane_data = st_data;
      lane_be   = 4'b0000;
      case (st_op)
         2'b00: begin
            accept_ok = (st_addr[1:0] == 2'b00);
            lane_data = st_data;
            lane_be   = 4'b1111;
         end
         2'b01: begin
            accept_ok = ~st_addr[0];
            lane_data = {2{st_data[15:0]}};
            lane_be   = st_addr[1] ? 4'b0011 : 4'b1100;
         end
         2'b10: begin
            accept_ok = 1'b1;
            lane_data = {4{st_data[7:0]}};
            lane_be   = 4'b1000 >> st_addr[1:0];
         end
         default: accept_ok = 1'b0;
      endcase
   end

   assign full      = (count == CW'(DEPTH));
   assign empty     = (count == '0);
   assign st_ready  = ~full;
   assign mem_req   = ~empty;
   // Full means no push even when the head is being acked this cycle.
   assign push      = st_valid & st_ready & accept_ok;
   assign pop       = mem_req & mem_ack;

   assign mem_addr  = {addr_q[rd_ptr], 2'b00};
   assign mem_wdata = data_q[rd_ptr];
   assign mem_be    = be_q[rd_ptr];

   // An entry is live when its distance from the head is below count.
   always_comb begin
      ld_hazard = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if ({1'b0, PW'(i) - rd_ptr} < CW'(count) &&
             addr_q[i] == ld_addr[31:2])
            ld_hazard = ld_valid;
      end
   end

   logic unused_ld_lsb;
   assign unused_ld_lsb = ^ld_addr[1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         st_misalign <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
            be_q[i]   <= '0;
         end
      end else begin
         st_misalign <= st_valid & ~accept_ok;
         if (push) begin
            addr_q[wr_ptr] <= st_addr[31:2];
            data_q[wr_ptr] <= lane_data;
            be_q[wr_ptr]   <= lane_be;
            wr_ptr         <= wr_ptr + 1'b1;
         end
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_st_align_buf.sv
// Directed bench for st_align_buf: alignment, lanes, BE, FIFO order, full,
// push+pop, load hazard and mid-operation reset.
module tb_st_align_buf;

   logic        clk = 1'b0;
   logic        rst;
   logic        st_valid;
   logic [1:0]  st_op;
   logic [31:0] st_addr;
   logic [31:0] st_data;
   logic        st_ready;
   logic        st_misalign;
   logic        ld_valid;
   logic [31:0] ld_addr;
   logic        ld_hazard;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ack;
   logic        empty;

   int errors = 0;
   int checks = 0;

   st_align_buf #(.DEPTH(2)) dut (
      .clk(clk), .rst(rst), .st_valid(st_valid), .st_op(st_op),
      .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
      .st_misalign(st_misalign), .ld_valid(ld_valid), .ld_addr(ld_addr),
      .ld_hazard(ld_hazard), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack), .empty(empty)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic store(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
      st_valid = 1'b1;
      st_op    = op;
      st_addr  = a;
      st_data  = d;
   endtask

   task automatic test_reset();
      rst = 1'b1; st_valid = 1'b0; st_op = 2'b00; st_addr = '0; st_data = '0;
      ld_valid = 1'b0; ld_addr = '0; mem_ack = 1'b0;
      step(); step();
      rst = 1'b0;
      checks++; if (st_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", st_ready); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", mem_req); end
      checks++; if ({mem_addr, mem_wdata, mem_be} !== 68'h0) begin errors++; $display("FAIL reset_outs got=%h/%h/%b exp=0", mem_addr, mem_wdata, mem_be); end
      checks++; if (st_misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign got=%b exp=0", st_misalign); end
   endtask

   task automatic test_sb();
      store(2'b10, 32'h1003, 32'h0000_00A5);
      #1;
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL sb_latency got=%b exp=0", mem_req); end
      step();
      st_valid = 1'b0;
      checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL sb_req got=%b exp=1", mem_req); end
      checks++; if (mem_addr !== 32'h1000) begin errors++; $display("FAIL sb_addr got=%h exp=00001000", mem_addr); end
      checks++; if (mem_wdata !== 32'hA5A5_A5A5) begin errors++; $display("FAIL sb_wdata got=%h exp=a5a5a5a5", mem_wdata); end
      checks++; if (mem_be !== 4'b0001) begin errors++; $display("FAIL sb_be got=%b exp=0001", mem_be); end
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL sb_drain got=%b exp=1", empty); end
   endtask

   task automatic test_sh_misalign();
      store(2'b01, 32'h2002, 32'h1234_BEEF);
      step();
      checks++; if (mem_wdata !== 32'hBEEF_BEEF) begin errors++; $display("FAIL sh_wdata got=%h exp=beefbeef", mem_wdata); end
      checks++; if (mem_be !== 4'b0011) begin errors++; $display("FAIL sh_be got=%b exp=0011", mem_be); end
      store(2'b01, 32'h2001, 32'h5555_6666);
      step();
      st_valid = 1'b0;
      checks++; if (st_misalign !== 1'b1) begin errors++; $display("FAIL sh_misalign got=%b exp=1", st_misalign); end
      checks++; if (st_ready !== 1'b1 || mem_addr !== 32'h2000 || mem_wdata !== 32'hBEEF_BEEF) begin
         errors++; $display("FAIL sh_queue_unchanged got=%b/%h/%h exp=1/00002000/beefbeef", st_ready, mem_addr, mem_wdata); end
      step();
      checks++; if (st_misalign !== 1'b0) begin errors++; $display("FAIL sh_pulse_width got=%b exp=0", st_misalign); end
      store(2'b11, 32'h2000, 32'h0);
      step();
      st_valid = 1'b0;
      checks++; if (st_misalign !== 1'b1) begin errors++; $display("FAIL illegal_op got=%b exp=1", st_misalign); end
      store(2'b00, 32'h2006, 32'h0);
      step();
      st_valid = 1'b0;
      checks++; if (st_misalign !== 1'b1) begin errors++; $display("FAIL sw_misalign got=%b exp=1", st_misalign); end
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL sh_only_one_entry got=%b exp=1", empty); end
   endtask

   task automatic test_full_order();
      store(2'b00, 32'h10, 32'hAAAA_0010);
      step();
      store(2'b00, 32'h14, 32'hAAAA_0014);
      step();
      checks++; if (st_ready !== 1'b0) begin errors++; $display("FAIL full_ready got=%b exp=0", st_ready); end
      store(2'b00, 32'h18, 32'hAAAA_0018);
      step();
      checks++; if (st_ready !== 1'b0 || mem_addr !== 32'h10) begin errors++; $display("FAIL full_hold got=%b/%h exp=0/00000010", st_ready, mem_addr); end
      checks++; if (mem_wdata !== 32'hAAAA_0010 || mem_be !== 4'b1111) begin errors++; $display("FAIL sw_lanes got=%h/%b exp=aaaa0010/1111", mem_wdata, mem_be); end
      mem_ack = 1'b1;
      step();
      checks++; if (mem_addr !== 32'h14 || st_ready !== 1'b1) begin errors++; $display("FAIL drain_2nd got=%h/%b exp=00000014/1", mem_addr, st_ready); end
      step();
      st_valid = 1'b0;
      checks++; if (mem_addr !== 32'h18 || mem_wdata !== 32'hAAAA_0018) begin errors++; $display("FAIL drain_3rd got=%h/%h exp=00000018/aaaa0018", mem_addr, mem_wdata); end
      step();
      mem_ack = 1'b0;
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty got=%b exp=1", empty); end
   endtask

   task automatic test_hazard();
      store(2'b00, 32'h3000, 32'h1);
      step();
      st_valid = 1'b0;
      ld_valid = 1'b1; ld_addr = 32'h3002; #1;
      checks++; if (ld_hazard !== 1'b1) begin errors++; $display("FAIL hazard_match got=%b exp=1", ld_hazard); end
      ld_addr = 32'h3004; #1;
      checks++; if (ld_hazard !== 1'b0) begin errors++; $display("FAIL hazard_nextword got=%b exp=0", ld_hazard); end
      ld_valid = 1'b0; ld_addr = 32'h3000; #1;
      checks++; if (ld_hazard !== 1'b0) begin errors++; $display("FAIL hazard_noload got=%b exp=0", ld_hazard); end
      ld_valid = 1'b1; mem_ack = 1'b1; #1;
      checks++; if (ld_hazard !== 1'b1) begin errors++; $display("FAIL hazard_acked_head got=%b exp=1", ld_hazard); end
      step();
      mem_ack = 1'b0;
      checks++; if (ld_hazard !== 1'b0) begin errors++; $display("FAIL hazard_after_pop got=%b exp=0", ld_hazard); end
      ld_valid = 1'b0;
   endtask

   task automatic test_back_to_back();
      store(2'b00, 32'h40, 32'h1);
      step();
      store(2'b10, 32'h45, 32'h77);
      mem_ack = 1'b1;
      step();
      st_valid = 1'b0;
      mem_ack = 1'b0;
      checks++; if (mem_addr !== 32'h44 || mem_wdata !== 32'h7777_7777 || mem_be !== 4'b0100) begin
         errors++; $display("FAIL pushpop_head got=%h/%h/%b exp=00000044/77777777/0100", mem_addr, mem_wdata, mem_be); end
      checks++; if (mem_req !== 1'b1 || st_ready !== 1'b1) begin errors++; $display("FAIL pushpop_count got=%b/%b exp=1/1", mem_req, st_ready); end
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL pushpop_one_left got=%b exp=1", empty); end
   endtask

   task automatic test_reset_mid();
      store(2'b00, 32'h50, 32'h5050_5050);
      step();
      store(2'b00, 32'h54, 32'h5454_5454);
      step();
      store(2'b00, 32'h58, 32'h5858_5858);
      rst = 1'b1;
      step();
      rst = 1'b0;
      st_valid = 1'b0;
      checks++; if (mem_req !== 1'b0 || empty !== 1'b1 || st_ready !== 1'b1) begin
         errors++; $display("FAIL rst_mid_flags got=%b/%b/%b exp=0/1/1", mem_req, empty, st_ready); end
      checks++; if ({mem_addr, mem_wdata, mem_be} !== 68'h0) begin errors++; $display("FAIL rst_mid_outs got=%h/%h/%b exp=0", mem_addr, mem_wdata, mem_be); end
      step();
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_store_discarded got=%b exp=1", empty); end
   endtask

   initial begin
      test_reset();
      test_sb();
      test_sh_misalign();
      test_full_order();
      test_hazard();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
